// File: rtl/dm_responder_if.sv
// dm_responder_if
//   Bundles the core-side data-memory port and the MMIO side channels
//   (byte transmit and halt/exit) of dm_responder.
//   master : core / bench side. It drives the address, write data, byte
//            enables and tx_ready.
//   slave  : dm_responder. It drives rdata, tx_valid/tx_data and
//            halt/exit_code.
//   Signals:
//     dm_addr   32  byte address
//     dm_wdata  32  lane-aligned store data
//     dm_web     4  active-low byte write enables (4'b1111 = no write)
//     dm_rdata  32  combinational read data
//     tx_valid   1  transmit byte available
//     tx_data    8  transmit byte
//     tx_ready   1  sink accepts byte
//     halt       1  program finished (sticky)
//     exit_code 31  value written with the halt
interface dm_responder_if;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_web;
  logic [31:0] dm_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic [30:0] exit_code;

  modport master (
    output dm_addr, dm_wdata, dm_web, tx_ready,
    input  dm_rdata, tx_valid, tx_data, halt, exit_code
  );

  modport slave (
    input  dm_addr, dm_wdata, dm_web, tx_ready,
    output dm_rdata, tx_valid, tx_data, halt, exit_code
  );
endinterface

// File: rtl/dm_responder.sv
// dm_responder
//   Data-memory responder for the core's data port. It provides a
//   word-organised RAM with a combinational read and a byte-masked
//   synchronous write. It can also provide an MMIO window with a 64-bit
//   cycle counter, a halt/exit register and a buffered transmit FIFO.
//   Build option: define DM_MMIO_EN to include the MMIO window.
//   When DM_MMIO_EN is undefined, every address maps to RAM and the
//   halt/tx outputs are tied to 0.
//   Ports:
//     clk  clock
//     rst  asynchronous active-high reset
//     bus  dm_responder_if.slave (data port plus tx/halt side channels)
//   Parameters:
//     DEPTH      RAM words (power of two)
//     MMIO_BASE  MMIO window base; only bits [31:16] are decoded
//     FIFO_DEPTH transmit FIFO entries (power of two, >= 2)
module dm_responder #(
  parameter int          DEPTH      = 16384,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  dm_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  // Merge the enabled byte lanes of nw into old. The enables are active-low.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] nw,
                                              input logic [3:0]  web);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (!web[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] widx;
  logic [31:0]   ram_rdata;
  logic          ram_sel;
  logic          any_we;
  logic          unused_addr;

  assign widx        = bus.dm_addr[AW+1:2];
  assign ram_rdata   = mem_q[widx];
  assign any_we      = (bus.dm_web != 4'hF);
  // The upper address bits alias the RAM. Byte-offset bits are ignored.
  assign unused_addr = ^{bus.dm_addr[31:AW+2], bus.dm_addr[1:0]};

  // RAM contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (ram_sel && any_we)
      mem_q[widx] <= merge_bytes(ram_rdata, bus.dm_wdata, bus.dm_web);
  end

`ifdef DM_MMIO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic          mmio_hit;
  logic [2:0]    off;
  logic [63:0]   mtime_q, mtime_d;
  logic          halt_q;
  logic [30:0]   exit_q;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          lo_we, hi_we, host_we, push_req, pop, full, push_ok;
  logic [31:0]   mmio_rdata;

  assign mmio_hit = (bus.dm_addr[31:16] == MMIO_BASE[31:16]);
  assign ram_sel  = !mmio_hit;
  assign off      = bus.dm_addr[4:2];

  assign lo_we    = mmio_hit && (off == 3'd0) && any_we;
  assign hi_we    = mmio_hit && (off == 3'd1) && any_we;
  assign host_we  = mmio_hit && (off == 3'd2) && !bus.dm_web[0] && !halt_q;
  assign push_req = mmio_hit && (off == 3'd3) && !bus.dm_web[0];

  assign full     = (cnt_q == FULL_CNT);
  assign pop      = (cnt_q != '0) && bus.tx_ready;
  // A push into a full FIFO still succeeds when a pop frees a slot on the same edge.
  assign push_ok  = push_req && (!full || pop);

  // A written half replaces that cycle's increment. No carry crosses into the other half.
  always_comb begin
    mtime_d = mtime_q + 64'd1;
    if (lo_we)
      mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], bus.dm_wdata, bus.dm_web)};
    else if (hi_we)
      mtime_d = {merge_bytes(mtime_q[63:32], bus.dm_wdata, bus.dm_web), mtime_q[31:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q  <= '0;
      halt_q   <= 1'b0;
      exit_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      if (host_we) begin
        halt_q <= 1'b1;
        exit_q <= bus.dm_wdata[31:1];
      end
      if (push_req && !push_ok) ovf_q <= 1'b1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage is not reset. The tx_data gate hides stale entries.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= bus.dm_wdata[7:0];
  end

  always_comb begin
    case (off)
      3'd0:    mmio_rdata = mtime_q[31:0];
      3'd1:    mmio_rdata = mtime_q[63:32];
      3'd2:    mmio_rdata = {exit_q, halt_q};
      3'd4:    mmio_rdata = {24'b0, 4'(cnt_q), 2'b0, ovf_q, halt_q};
      default: mmio_rdata = 32'h0;
    endcase
  end

  assign bus.dm_rdata  = mmio_hit ? mmio_rdata : ram_rdata;
  assign bus.tx_valid  = (cnt_q != '0);
  assign bus.tx_data   = (cnt_q != '0) ? fifo_q[rd_ptr_q] : 8'h00;
  assign bus.halt      = halt_q;
  assign bus.exit_code = exit_q;
`else
  logic unused_rdy;

  assign ram_sel       = 1'b1;
  assign unused_rdy    = bus.tx_ready;
  assign bus.dm_rdata  = ram_rdata;
  assign bus.tx_valid  = 1'b0;
  assign bus.tx_data   = 8'h00;
  assign bus.halt      = 1'b0;
  assign bus.exit_code = 31'h0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
`timescale 1ns/1ps
module tb_dm_responder;
  localparam int          DEPTH = 16384;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_responder_if bus();

  dm_responder #(.DEPTH(DEPTH), .MMIO_BASE(BASE), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] web);
    bus.dm_addr  = a;
    bus.dm_wdata = d;
    bus.dm_web   = web;
    @(posedge clk);
    #1;
    bus.dm_web   = 4'hF;
    bus.dm_wdata = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.dm_addr = a;
    bus.dm_web  = 4'hF;
    #1;
    d = bus.dm_rdata;
  endtask

`ifdef DM_MMIO_EN
  // Scoreboard of bytes expected on the transmit handshake, in order.
  logic [7:0] exp_q[$];
  int         hs_cnt  = 0;
  logic [7:0] last_tx = 8'h00;

  always @(negedge clk) begin
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      hs_cnt++;
      last_tx = bus.tx_data;
      if (exp_q.size() == 0) check_eq("tx_unexpected", 32'(bus.tx_data), 32'hFFFF_FFFF);
      else check_eq("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tx_push(input logic [7:0] b, input bit accept);
    if (accept) exp_q.push_back(b);
    wr(BASE + 32'hC, {24'hABCDEF, b}, 4'b1110);
  endtask
`endif

  initial begin
    logic [31:0] v;
    bus.dm_addr  = 32'h0;
    bus.dm_wdata = 32'h0;
    bus.dm_web   = 4'hF;
    bus.tx_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rst_halt", 32'(bus.halt), 32'h0);
    check_eq("rst_exit", 32'(bus.exit_code), 32'h0);
    check_eq("rst_txvalid", 32'(bus.tx_valid), 32'h0);
    check_eq("rst_txdata", 32'(bus.tx_data), 32'h0);
`ifdef DM_MMIO_EN
    rd(BASE + 32'h10, v);
    check_eq("rst_status", v, 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

`ifdef DM_MMIO_EN
    // Counter checks
    repeat (10) @(posedge clk);
    #1;
    rd(BASE, v);
    check_eq("mtime_c10", v, 32'd10);
    @(posedge clk); #1;
    rd(BASE, v);
    check_eq("mtime_c11", v, 32'd11);
    wr(BASE, 32'hFFFF_FFFF, 4'b0000);
    rd(BASE, v);
    check_eq("mtime_lo_wr", v, 32'hFFFF_FFFF);
    rd(BASE + 32'h4, v);
    check_eq("mtime_hi_hold", v, 32'h0);
    @(posedge clk); #1;
    rd(BASE, v);
    check_eq("mtime_lo_wrap", v, 32'h0);
    rd(BASE + 32'h4, v);
    check_eq("mtime_hi_carry", v, 32'h1);
`endif

    // Byte-masked RAM store and alias
    wr(32'h100, 32'hAABB_CCDD, 4'b0000);
    wr(32'h100, 32'h0000_1100, 4'b1101);
    rd(32'h100, v);
    check_eq("ram_mask", v, 32'hAABB_11DD);
    rd(32'h100 + 4 * DEPTH, v);
    check_eq("ram_alias", v, 32'hAABB_11DD);
    rd(32'hFFFE_0101, v);
    check_eq("ram_alias_hi", v, 32'hAABB_11DD);

    // A read in the write cycle sees the old word
    wr(32'h200, 32'h1234_5678, 4'b0000);
    bus.dm_addr  = 32'h200;
    bus.dm_wdata = 32'hCAFE_F00D;
    bus.dm_web   = 4'b0000;
    #1;
    check_eq("ram_rd_old", bus.dm_rdata, 32'h1234_5678);
    @(posedge clk); #1;
    bus.dm_web = 4'hF;
    #1;
    check_eq("ram_rd_new", bus.dm_rdata, 32'hCAFE_F00D);
    wr(32'h200, 32'h1122_3344, 4'b0111);
    rd(32'h200, v);
    check_eq("ram_lane3", v, 32'h11FE_F00D);

`ifndef DM_MMIO_EN
    // Without MMIO the base window is plain RAM and the side outputs stay 0
    bus.tx_ready = 1'b1;
    wr(BASE + 32'h8, 32'hDEAD_BEEF, 4'b0000);
    wr(BASE + 32'hC, 32'h0000_0041, 4'b0000);
    rd(32'h8, v);
    check_eq("nommio_alias", v, 32'hDEAD_BEEF);
    rd(BASE + 32'hC, v);
    check_eq("nommio_ram", v, 32'h0000_0041);
    check_eq("nommio_halt", 32'(bus.halt), 32'h0);
    check_eq("nommio_exit", 32'(bus.exit_code), 32'h0);
    check_eq("nommio_txvalid", 32'(bus.tx_valid), 32'h0);
    check_eq("nommio_txdata", 32'(bus.tx_data), 32'h0);
    bus.tx_ready = 1'b0;
`else
    // Unmapped offset
    wr(BASE + 32'h14, 32'hFFFF_FFFF, 4'b0000);
    rd(BASE + 32'h14, v);
    check_eq("off5_zero", v, 32'h0);

    // Halt
    check_eq("halt_pre", 32'(bus.halt), 32'h0);
    wr(BASE + 32'h8, 32'h0000_0001, 4'b0000);
    check_eq("halt_set", 32'(bus.halt), 32'h1);
    check_eq("halt_exit", 32'(bus.exit_code), 32'h0);
    rd(BASE + 32'h8, v);
    check_eq("tohost_rd", v, 32'h1);
    wr(BASE + 32'h8, 32'h0000_0055, 4'b0000);
    check_eq("halt_sticky_exit", 32'(bus.exit_code), 32'h0);
    rd(BASE + 32'h10, v);
    check_eq("status_halt", v, 32'h1);

    // FIFO fill and overflow
    bus.tx_ready = 1'b0;
    tx_push(8'h41, 1'b1);
    tx_push(8'h42, 1'b1);
    tx_push(8'h43, 1'b1);
    tx_push(8'h44, 1'b1);
    tx_push(8'h45, 1'b0);
    rd(BASE + 32'h10, v);
    check_eq("status_full_ovf", v, 32'h43);
    check_eq("full_txvalid", 32'(bus.tx_valid), 32'h1);
    check_eq("full_txdata", 32'(bus.tx_data), 32'h41);
    rd(BASE + 32'hC, v);
    check_eq("txdata_rd", v, 32'h0);
    hs_cnt = 0;
    bus.tx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("drain_hs", 32'(hs_cnt), 32'd4);
    check_eq("drain_txvalid", 32'(bus.tx_valid), 32'h0);
    check_eq("drain_sb_empty", 32'(exp_q.size()), 32'd0);

    // Full push+pop
    bus.tx_ready = 1'b0;
    tx_push(8'h61, 1'b1);
    tx_push(8'h62, 1'b1);
    tx_push(8'h63, 1'b1);
    tx_push(8'h64, 1'b1);
    hs_cnt = 0;
    bus.tx_ready = 1'b1;
    tx_push(8'h5A, 1'b1);
    rd(BASE + 32'h10, v);
    check_eq("pushpop_status", v, 32'h43);
    repeat (4) @(posedge clk);
    #1;
    check_eq("pushpop_hs", 32'(hs_cnt), 32'd5);
    check_eq("pushpop_last", 32'(last_tx), 32'h5A);
    check_eq("pushpop_txvalid", 32'(bus.tx_valid), 32'h0);

    // Reset mid-stream
    bus.tx_ready = 1'b0;
    tx_push(8'h71, 1'b1);
    tx_push(8'h72, 1'b1);
    tx_push(8'h73, 1'b1);
    rd(BASE + 32'h10, v);
    check_eq("pre_rst_status", v, 32'h33);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_eq("midrst_txvalid", 32'(bus.tx_valid), 32'h0);
    check_eq("midrst_halt", 32'(bus.halt), 32'h0);
    check_eq("midrst_status", bus.dm_rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    tx_push(8'h7E, 1'b1);
    rd(BASE + 32'h10, v);
    check_eq("post_rst_status", v, 32'h10);
    check_eq("post_rst_txdata", 32'(bus.tx_data), 32'h7E);
    hs_cnt = 0;
    bus.tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("post_rst_hs", 32'(hs_cnt), 32'd1);
    check_eq("post_rst_empty", 32'(bus.tx_valid), 32'h0);
    bus.tx_ready = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
